// File: rtl/gf_pkg.sv
// -----------------------------------------------------------------------------
// gf_pkg
// Shared GF(2^8) definitions for the Reed-Solomon datapath (gf_poly_div and
// gf_poly_mul): field constants, polynomial bus geometry, the divider FSM
// state encoding and the scalar field multiplier function.
// No ports (package).
// -----------------------------------------------------------------------------
package gf_pkg;

  // Field order minus one; GF(2^8) generated by x^8+x^4+x^3+x^2+1 (0x11D).
  localparam int m = 255;
  localparam int SIZE = $clog2(m);
  // Low byte of 0x11D; the x^8 term is implied by the shift-out bit.
  localparam logic [7:0] PRIM_POLY = 8'h1D;

  // Divisor degree and derived bus widths.
  localparam int N           = 2;
  localparam int FLAT_SIZE   = (N + 1) * SIZE;
  localparam int LARGE_ARRAY = 2 * N;
  localparam int LARGE_SIZE  = (LARGE_ARRAY + 1) * SIZE;
  localparam int REM_SIZE    = N * SIZE;

  // Counter covers the 7 inversion squarings and the N+1 division steps.
  localparam int CNT_W  = ($clog2(N + 1) > 3) ? $clog2(N + 1) : 3;
  // Index widths for the working dividend and the quotient arrays.
  localparam int IDX_W  = $clog2(LARGE_ARRAY + 1);
  localparam int QIDX_W = ($clog2(N + 1) > 0) ? $clog2(N + 1) : 1;

  typedef logic [SIZE-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Shift-and-add GF(2^8) product, reduced modulo 0x11D on every shift.
  function automatic coef_t gf_mul(input coef_t a, input coef_t b);
    coef_t p;
    coef_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      if (x[SIZE-1]) begin
        x = (x << 1) ^ PRIM_POLY;
      end else begin
        x = x << 1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/gf_poly_div_if.sv
// -----------------------------------------------------------------------------
// gf_poly_div_if
// Request/result bundle of the polynomial divider.
//   start  : request, sampled by the divider only while idle
//   flat_a : dividend, coeff i at [i*SIZE +: SIZE], i=0 is the constant term
//   flat_b : divisor, same packing, coeff N is the leading term
//   busy   : division in progress
//   done   : one-cycle pulse, results valid
//   err    : valid with done, divisor rejected (zero / non-monic lead)
//   flat_q : quotient, same packing
//   flat_r : remainder, coeffs 0..N-1
// master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface gf_poly_div_if
  import gf_pkg::*;
  ;
  logic                  start;
  logic [LARGE_SIZE-1:0] flat_a;
  logic [FLAT_SIZE-1:0]  flat_b;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [FLAT_SIZE-1:0]  flat_q;
  logic [REM_SIZE-1:0]   flat_r;

  modport master (
    output start, flat_a, flat_b,
    input  busy, done, err, flat_q, flat_r
  );

  modport slave (
    input  start, flat_a, flat_b,
    output busy, done, err, flat_q, flat_r
  );
endinterface

// File: rtl/gf_mul.sv
// -----------------------------------------------------------------------------
// gf_mul
// Combinational 8x8 GF(2^8) multiplier (mod 0x11D).
//   a_i : first operand
//   b_i : second operand
//   p_o : product
// -----------------------------------------------------------------------------
module gf_mul (
  input  gf_pkg::coef_t a_i,
  input  gf_pkg::coef_t b_i,
  output gf_pkg::coef_t p_o
);

  assign p_o = gf_pkg::gf_mul(a_i, b_i);

endmodule

// File: rtl/gf_poly_div.sv
// -----------------------------------------------------------------------------
// gf_poly_div
// Sequential GF(2^8) polynomial long divider: dividend of degree 2N divided by
// a divisor of degree N, giving an (N+1)-coefficient quotient and an
// N-coefficient remainder. Used for RS encoder parity and decoder checks.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; aborts any division in flight
//   bus : gf_poly_div_if.slave (start/flat_a/flat_b in; busy/done/err/
//         flat_q/flat_r out)
// Flow: IDLE -> INV (7 cycles, b[N]^254 = b[N]^-1) -> DIV (N+1 cycles) ->
// DONE (1 cycle, done=1) -> IDLE. A zero leading divisor coefficient jumps
// straight to DONE with err=1 and zero results.
// Build option GF_DIV_MONIC_EN: divisor must be monic, the inverse is fixed
// at 1 and INV collapses to a single setup cycle; b[N]!=1 is reported as err.
// -----------------------------------------------------------------------------
module gf_poly_div
  import gf_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  gf_poly_div_if.slave bus
);

  localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(6);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  coef_t                sq_q, sq_d;
  coef_t                inv_q, inv_d;       // accumulator during INV, inverse after
  coef_t                r_q [0:LARGE_ARRAY];
  coef_t                r_d [0:LARGE_ARRAY];
  coef_t                b_q [0:N];
  coef_t                b_d [0:N];
  coef_t                qw_q [0:N];
  coef_t                qw_d [0:N];
  logic [FLAT_SIZE-1:0] flat_q_q, flat_q_d;
  logic [REM_SIZE-1:0]  flat_r_q, flat_r_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  coef_t                m0_a_s, m0_b_s, m0_p_s;
  coef_t                m1_p_s;
  coef_t                row_p_s [0:N];
  coef_t                lead_in_s;
  logic [IDX_W-1:0]     j_s;
  logic [IDX_W-1:0]     base_s;
  logic [QIDX_W-1:0]    qidx_s;

  assign lead_in_s = bus.flat_b[N*SIZE +: SIZE];

  // Step k = cnt: leading term j = 2N-k, row update starts at N-k.
  assign j_s    = IDX_W'(LARGE_ARRAY) - IDX_W'(cnt_q);
  assign base_s = IDX_W'(N) - IDX_W'(cnt_q);
  assign qidx_s = QIDX_W'(N) - QIDX_W'(cnt_q);

  // Operand select for the shared multiplier: squaring in INV, quotient coeff in DIV.
  always_comb begin
    m0_a_s = '0;
    m0_b_s = '0;
    case (state_q)
      INV: begin
        m0_a_s = sq_q;
        m0_b_s = sq_q;
      end
      DIV: begin
        m0_a_s = r_q[j_s];
        m0_b_s = inv_q;
      end
      default: begin
        m0_a_s = '0;
        m0_b_s = '0;
      end
    endcase
  end

  gf_mul u_mul_sq (
    .a_i (m0_a_s),
    .b_i (m0_b_s),
    .p_o (m0_p_s)
  );

  // acc * sq^2; only consumed during INV.
  gf_mul u_mul_acc (
    .a_i (inv_q),
    .b_i (m0_p_s),
    .p_o (m1_p_s)
  );

  // Row update products q[N-k] * b[i].
  for (genvar g = 0; g <= N; g++) begin : g_row
    gf_mul u_mul_row (
      .a_i (m0_p_s),
      .b_i (b_q[g]),
      .p_o (row_p_s[g])
    );
  end

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    inv_d    = inv_q;
    r_d      = r_q;
    b_d      = b_q;
    qw_d     = qw_q;
    flat_q_d = flat_q_q;
    flat_r_d = flat_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i <= LARGE_ARRAY; i++) begin
            r_d[i] = bus.flat_a[i*SIZE +: SIZE];
          end
          for (int i = 0; i <= N; i++) begin
            b_d[i]  = bus.flat_b[i*SIZE +: SIZE];
            qw_d[i] = '0;
          end
          cnt_d = '0;
          sq_d  = lead_in_s;
          inv_d = 8'h01;
`ifdef GF_DIV_MONIC_EN
          if (lead_in_s != 8'h01) begin
`else
          if (lead_in_s == 8'h00) begin
`endif
            // Rejected divisor: report immediately with cleared results.
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            err_d    = 1'b1;
            flat_q_d = '0;
            flat_r_d = '0;
          end else begin
            state_d = INV;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      INV: begin
`ifdef GF_DIV_MONIC_EN
        // Inverse of a monic lead is 1; this cycle only sets up DIV.
        state_d = DIV;
        cnt_d   = '0;
`else
        // After 7 steps acc = b^(2+4+...+128) = b^254 = b^-1.
        sq_d  = m0_p_s;
        inv_d = m1_p_s;
        if (cnt_q == INV_LAST) begin
          state_d = DIV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DIV: begin
        qw_d[qidx_s] = m0_p_s;
        // Subtracting q*b cancels r[j] exactly because q = r[j]/b[N].
        for (int i = 0; i <= N; i++) begin
          r_d[base_s + IDX_W'(i)] = r_q[base_s + IDX_W'(i)] ^ row_p_s[i];
        end
        if (cnt_q == DIV_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          for (int i = 0; i <= N; i++) begin
            flat_q_d[i*SIZE +: SIZE] = qw_d[i];
          end
          for (int i = 0; i < N; i++) begin
            flat_r_d[i*SIZE +: SIZE] = r_d[i];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sq_q     <= '0;
      inv_q    <= '0;
      for (int i = 0; i <= LARGE_ARRAY; i++) begin
        r_q[i] <= '0;
      end
      for (int i = 0; i <= N; i++) begin
        b_q[i]  <= '0;
        qw_q[i] <= '0;
      end
      flat_q_q <= '0;
      flat_r_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      inv_q    <= inv_d;
      r_q      <= r_d;
      b_q      <= b_d;
      qw_q     <= qw_d;
      flat_q_q <= flat_q_d;
      flat_r_q <= flat_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.flat_q = flat_q_q;
  assign bus.flat_r = flat_r_q;

endmodule
